mat_vec_mac: RTL
================

// Module: mat_vec_mac
// PURPOSE
//  Parametrised NxN matrix times N-vector multiplier: c = A*b (+ c_prev when chaining).
//  Successor to the fixed 4x4 scheduled matrix block. Adds:
//   - generic size and width;
//   - start/busy/done handshake;
//   - signed or unsigned mode;
//   - accumulate mode for tiling larger matrices.
//  Sits between the operand register bank and the result writeback.
// PARAMETERS
//  N       4  matrix order and vector length (N>=2)
//  DW      7  element width of A and b
//  GUARD   2  extra accumulator headroom bits for chained accumulation
//  SIGNED  0  0: unsigned operands and results; 1: two's-complement operands and results
//  AW      derived, not overridable: 2*DW + $clog2(N) + GUARD
// PORTS
//  clk     in   1        single clock, rising edge
//  rst     in   1        synchronous, active-high reset
//  start   in   1        request; sampled only while busy=0
//  acc_en  in   1        sampled with start; 1 = add result onto current c
//  a_flat  in   N*N*DW   A[i][j] at bits [(i*N+j)*DW +: DW]
//  b_flat  in   N*DW     b[j] at bits [j*DW +: DW]
//  busy    out  1        high from the cycle after start accept until done falls
//  done    out  1        one-cycle pulse; c_flat is valid and updated
//  c_flat  out  N*AW     c[i] at bits [i*AW +: AW]; held until the next completion
// BEHAVIOUR
//  Reset (rst=1 at edge), whatever the current state:
//   - state=IDLE, k=0, busy=0, done=0, c_flat=0, operand and accumulator registers=0.
//   - A request in flight is discarded.
//  FSM states IDLE, RUN, DONE:
//   - IDLE: start=1 at edge E0 -> RUN. Edge E0 also:
//       latches a_flat, b_flat and acc_en into internal registers;
//       sets k=0;
//       loads acc[i] = acc_en ? c[i] : 0.
//   - RUN: at each edge, lane i does acc[i] += A[i][k]*b[k], then k++.
//       The edge with k=N-1 transfers acc into c_flat -> DONE.
//   - DONE: done=1 for exactly one cycle -> IDLE.
//  Latency: E0 is the start-accept edge.
//   - c_flat updates at edge E0+N.
//   - done=1 and busy=1 during the cycle following E0+N.
//   - busy=0 and done=0 in IDLE.
//   - Throughput is one result per N+2 cycles.
//  start while busy=1 (RUN or DONE): ignored; never queued.
//  Input ports a_flat, b_flat and acc_en may change freely after E0.
//  Arithmetic:
//   - Product is 2*DW bits, sign- or zero-extended to AW per SIGNED.
//   - The accumulator is AW bits and wraps modulo 2^AW with no saturation and no overflow flag.
//   - With GUARD=0 and acc_en=0, one pass cannot overflow.
//  acc_en=1 with c=0 (e.g. first request after reset) is identical to acc_en=0.
//  No combinational path from any input to any output; all outputs are registers.
// STRUCTURE
//  Package mat_vec_pkg:
//   - state enum {IDLE, RUN, DONE};
//   - function acc_width(N, DW, GUARD);
//   - localparams for the flat-vector index helpers.
//  Sub-module mac_lane (DW, AW, SIGNED), instantiated N times via generate.
//   - Ports: clk, rst, clr, load, load_val, en, a, b, acc.
//   - One multiplier plus one accumulator per row.
//  Top level holds the FSM, column counter k, operand registers and the c_flat register.
// TESTING
//  1. N=4 DW=7 unsigned, A=identity, b={1,2,3,4}
//     -> c={1,2,3,4}; done exactly 5 cycles after the accept edge; busy high for 5 cycles.
//  2. All 16 A entries=127, b all 127, acc_en=0
//     -> every c[i]=64516; no wrap at AW=18.
//  3. Run test 2, then start again with acc_en=1 and the same operands
//     -> every c[i]=129032.
//  4. SIGNED=1 DW=7, A row0={-64,-64,-64,-64}, b all -64
//     -> c[0]=16384; A row1={63,0,0,0} with b[0]=-64 -> c[1]=-4032.
//  5. start held high continuously
//     -> accepts exactly every N+2 cycles; start pulsed during RUN is ignored; c unchanged until done.
//  6. rst asserted at the 2nd RUN cycle
//     -> next cycle busy=0, done=0, c_flat=0; a fresh start then gives the correct result.

Source files
------------

// File: rtl/mat_vec_pkg.sv
// Shared types and index helpers for the NxN matrix-vector MAC block.
package mat_vec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Accumulator width: full product, growth over N terms, plus chaining headroom.
    function automatic int unsigned acc_width(input int unsigned n,
                                              input int unsigned dw,
                                              input int unsigned guard);
        return 2 * dw + $clog2(n) + guard;
    endfunction

    // LSB of A[i][j] inside the flattened matrix.
    function automatic int unsigned a_lsb(input int unsigned i,
                                          input int unsigned j,
                                          input int unsigned n,
                                          input int unsigned dw);
        return (i * n + j) * dw;
    endfunction

    // LSB of b[j] inside the flattened vector.
    function automatic int unsigned b_lsb(input int unsigned j,
                                          input int unsigned dw);
        return j * dw;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One row lane: multiplier plus AW-bit wrapping accumulator.
module mac_lane #(
    parameter int unsigned DW     = 7,
    parameter int unsigned AW     = 18,
    parameter int          SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic [2*DW-1:0] a_ext;
    logic [2*DW-1:0] b_ext;
    logic [2*DW-1:0] prod;
    logic [AW-1:0]   prod_ext;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic            sa;
    logic            sb;
    logic            sp;

    // Extend operands to full product width so a plain modular multiply
    // yields the correct signed or unsigned product.
    always_comb begin
        sa       = (SIGNED != 0) & a[DW-1];
        sb       = (SIGNED != 0) & b[DW-1];
        a_ext    = {{DW{sa}}, a};
        b_ext    = {{DW{sb}}, b};
        prod     = a_ext * b_ext;
        sp       = (SIGNED != 0) & prod[2*DW-1];
        prod_ext = {{(AW-2*DW){sp}}, prod};
    end

    // acc exposes the running sum including this cycle's product, so the
    // top can capture the final result on the same edge as the last MAC.
    always_comb begin
        acc = acc_q + (en ? prod_ext : '0);
    end

    // Accumulator next-state: clear, preload, or accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (load) begin
            acc_d = load_val;
        end else if (en) begin
            acc_d = acc;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mat_vec_mac.sv
// NxN matrix times N-vector MAC with start/busy/done handshake and
// optional accumulation onto the previous result.
module mat_vec_mac
    import mat_vec_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DW     = 7,
    parameter int unsigned GUARD  = 2,
    parameter int          SIGNED = 0,
    localparam int unsigned AW    = acc_width(N, DW, GUARD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acc_en,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*DW-1:0]   b_flat,
    output logic              busy,
    output logic              done,
    output logic [N*AW-1:0]   c_flat
);

    localparam int unsigned KW = $clog2(N);

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [N*N*DW-1:0]   a_q, a_d;
    logic [N*DW-1:0]     b_q, b_d;
    logic [N*AW-1:0]     c_q, c_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;
    logic                run_en;
    logic [DW-1:0]       col_b;
    logic [N*AW-1:0]     lane_sum;

    assign col_b = b_q[b_lsb(32'(k_q), DW) +: DW];

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] row_a;
        assign row_a = a_q[a_lsb(gi, 32'(k_q), N, DW) +: DW];

        mac_lane #(
            .DW     (DW),
            .AW     (AW),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (accept & ~acc_en),
            .load     (accept & acc_en),
            .load_val (c_q[gi*AW +: AW]),
            .en       (run_en),
            .a        (row_a),
            .b        (col_b),
            .acc      (lane_sum[gi*AW +: AW])
        );
    end

    // Next-state, column counter, operand capture and result transfer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        accept  = 1'b0;
        run_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    a_d     = a_flat;
                    b_d     = b_flat;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                run_en = 1'b1;
                if (k_q == KW'(N - 1)) begin
                    state_d = DONE;
                    k_d     = '0;
                    c_d     = lane_sum;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, operand and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign c_flat = c_q;

endmodule
